// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: ResultSrc encodings and the writeback entry layout.
// Entry layout is {result, rd, regwrite}; the low WB_META_W bits hold rd and regwrite.
package pipeline_pkg;
    localparam int WB_XLEN   = 32;
    localparam int WB_META_W = 6;

    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_LOAD = 2'd1;
    localparam logic [1:0] RES_PC4  = 2'd2;
    localparam logic [1:0] RES_IMM  = 2'd3;

    typedef struct packed {
        logic [WB_XLEN-1:0] result;
        logic [4:0]         rd;
        logic               regwrite;
    } wb_entry_t;
endpackage

// File: rtl/mux4.sv
// Four-way result selector driven by a ResultSrc code.
module mux4
    import pipeline_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_y
);
    always_comb begin
        case (i_sel)
            RES_ALU:  o_y = i_d0;
            RES_LOAD: o_y = i_d1;
            RES_PC4:  o_y = i_d2;
            default:  o_y = i_d3;
        endcase
    end
endmodule

// File: rtl/wb_fifo.sv
// Per-channel writeback FIFO. Pointers carry an extra wrap bit to tell full from empty;
// every slot is exposed with its valid flag, rd and regwrite so the top can build rd_pending.
module wb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [W-1:0]          i_din,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [W-1:0]          o_head,
    output logic [DEPTH-1:0]      o_ent_valid,
    output logic [DEPTH-1:0][4:0] o_ent_rd,
    output logic [DEPTH-1:0]      o_ent_regwrite
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   w_count;
    logic          w_push;
    logic          w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: slot validity comes solely from the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] w_off;
            assign w_off              = AW'(gi) - r_rd_ptr[AW-1:0];
            assign o_ent_valid[gi]    = ({1'b0, w_off} < w_count);
            assign o_ent_rd[gi]       = r_mem[gi][5:1];
            assign o_ent_regwrite[gi] = r_mem[gi][0];
        end
    endgenerate
endmodule

// File: rtl/wb_merge.sv
// Multi-channel writeback merge: per-channel result select + FIFO, round-robin drain into one
// registered register-file write port, plus rd_pending. WB_RETIRE_CNT_EN adds a 64-bit retire counter.
module wb_merge
    import pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_ready,
    input  logic [NUM_CH-1:0][1:0]      ch_resultsrc,
    input  logic [NUM_CH-1:0][XLEN-1:0] ch_aluresult,
    input  logic [NUM_CH-1:0][XLEN-1:0] ch_loaddata,
    input  logic [NUM_CH-1:0][XLEN-1:0] ch_pcplus4,
    input  logic [NUM_CH-1:0][XLEN-1:0] ch_immext,
    input  logic [NUM_CH-1:0][4:0]      ch_rd,
    input  logic [NUM_CH-1:0]           ch_regwrite,
    output logic                        RegWriteW,
    output logic [4:0]                  RdW,
    output logic [XLEN-1:0]             ResultW,
    output logic [31:0]                 rd_pending
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]                 retire_cnt
`endif
);
    localparam int EW = XLEN + WB_META_W;
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]          w_full;
    logic [NUM_CH-1:0]          w_empty;
    logic [NUM_CH-1:0]          w_pop;
    logic [EW-1:0]              w_head [NUM_CH];
    logic [FIFO_DEPTH-1:0]      w_ent_valid [NUM_CH];
    logic [FIFO_DEPTH-1:0][4:0] w_ent_rd [NUM_CH];
    logic [FIFO_DEPTH-1:0]      w_ent_rw [NUM_CH];

    logic                       w_grant_any;
    logic [GW-1:0]              w_grant_idx;
    logic [EW-1:0]              w_grant_entry;
    int                         w_scan;
    logic [31:0]                w_pending;

    logic                       r_regwrite;
    logic [4:0]                 r_rd;
    logic [XLEN-1:0]            r_result;
    logic [GW-1:0]              r_last_grant;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [XLEN-1:0] w_sel;
            logic [EW-1:0]   w_din;

            mux4 #(.W(XLEN)) u_mux (
                .i_d0  (ch_aluresult[gi]),
                .i_d1  (ch_loaddata[gi]),
                .i_d2  (ch_pcplus4[gi]),
                .i_d3  (ch_immext[gi]),
                .i_sel (ch_resultsrc[gi]),
                .o_y   (w_sel)
            );

            assign w_din = {w_sel, ch_rd[gi], ch_regwrite[gi]};

            wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_push         (ch_valid[gi]),
                .i_din          (w_din),
                .i_pop          (w_pop[gi]),
                .o_full         (w_full[gi]),
                .o_empty        (w_empty[gi]),
                .o_head         (w_head[gi]),
                .o_ent_valid    (w_ent_valid[gi]),
                .o_ent_rd       (w_ent_rd[gi]),
                .o_ent_regwrite (w_ent_rw[gi])
            );

            assign ch_ready[gi] = !w_full[gi];
            assign w_pop[gi]    = w_grant_any && (w_grant_idx == GW'(gi));
        end
    endgenerate

    // Round-robin: scan starts one past the last grant and takes the first non-empty FIFO.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_scan = (int'(r_last_grant) + k) % NUM_CH;
            if (!w_grant_any && !w_empty[w_scan]) begin
                w_grant_any = 1'b1;
                w_grant_idx = GW'(w_scan);
            end
        end
    end

    assign w_grant_entry = w_head[w_grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite   <= 1'b0;
            r_rd         <= '0;
            r_result     <= '0;
            r_last_grant <= GW'(NUM_CH - 1);
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_idx;
            r_result     <= w_grant_entry[EW-1:WB_META_W];
            r_rd         <= w_grant_entry[5:1];
            r_regwrite   <= w_grant_entry[0] && (w_grant_entry[5:1] != 5'd0);
        end else begin
            r_regwrite   <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_grant_any) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

    always_comb begin
        w_pending = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (w_ent_valid[c][e] && w_ent_rw[c][e]) w_pending[w_ent_rd[c][e]] = 1'b1;
            end
        end
        if (r_regwrite) w_pending[r_rd] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign rd_pending = w_pending;
    assign RegWriteW  = r_regwrite;
    assign RdW        = r_rd;
    assign ResultW    = r_result;
endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus random traffic, all checked
// against a queue-based model of the per-channel FIFOs, round-robin drain and output port.
module tb_wb_merge;
    localparam int XLEN  = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NCH-1:0]           ch_valid;
    logic [NCH-1:0]           ch_ready;
    logic [NCH-1:0][1:0]      ch_resultsrc;
    logic [NCH-1:0][XLEN-1:0] ch_aluresult;
    logic [NCH-1:0][XLEN-1:0] ch_loaddata;
    logic [NCH-1:0][XLEN-1:0] ch_pcplus4;
    logic [NCH-1:0][XLEN-1:0] ch_immext;
    logic [NCH-1:0][4:0]      ch_rd;
    logic [NCH-1:0]           ch_regwrite;
    logic                     RegWriteW;
    logic [4:0]               RdW;
    logic [XLEN-1:0]          ResultW;
    logic [31:0]              rd_pending;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]              retire_cnt;
`endif

    wb_merge #(.XLEN(XLEN), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_resultsrc (ch_resultsrc),
        .ch_aluresult (ch_aluresult),
        .ch_loaddata  (ch_loaddata),
        .ch_pcplus4   (ch_pcplus4),
        .ch_immext    (ch_immext),
        .ch_rd        (ch_rd),
        .ch_regwrite  (ch_regwrite),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .rd_pending   (rd_pending)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        logic            rw;
    } ent_t;

    ent_t            q [NCH][$];
    int              m_last;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_res;
    logic [63:0]     m_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] pick(input int i);
        case (ch_resultsrc[i])
            2'd0:    return ch_aluresult[i];
            2'd1:    return ch_loaddata[i];
            2'd2:    return ch_pcplus4[i];
            default: return ch_immext[i];
        endcase
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        for (int c = 0; c < NCH; c++)
            foreach (q[c][e]) if (q[c][e].rw) p[q[c][e].rd] = 1'b1;
        if (m_we) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) q[c].delete();
        m_last = NCH - 1;
        m_we   = 1'b0;
        m_rd   = '0;
        m_res  = '0;
        m_cnt  = '0;
    endtask

    task automatic check_all();
        logic [NCH-1:0] rdy;
        for (int c = 0; c < NCH; c++) rdy[c] = (q[c].size() < DEPTH);
        chk("regwrite", 64'(RegWriteW), 64'(m_we));
        chk("rd", 64'(RdW), 64'(m_rd));
        chk("result", 64'(ResultW), 64'(m_res));
        chk("ready", 64'(ch_ready), 64'(rdy));
        chk("pending", 64'(rd_pending), 64'(model_pending()));
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
    endtask

    // One clock: the model evaluates the cycle from pre-edge state, then the DUT is sampled 1ns after the edge.
    task automatic step();
        logic [NCH-1:0] rdy;
        int   g;
        ent_t e;
        for (int c = 0; c < NCH; c++) rdy[c] = (q[c].size() < DEPTH);
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (m_last + k) % NCH;
            if (g < 0 && q[idx].size() > 0) g = idx;
        end
        if (g >= 0) begin
            e      = q[g].pop_front();
            m_last = g;
            m_we   = e.rw && (e.rd != 5'd0);
            m_rd   = e.rd;
            m_res  = e.res;
            m_cnt  = m_cnt + 64'd1;
        end else begin
            m_we = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (ch_valid[c] && rdy[c]) begin
                e.res = pick(c);
                e.rd  = ch_rd[c];
                e.rw  = ch_regwrite[c];
                q[c].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        ch_valid     = '0;
        ch_resultsrc = '0;
        ch_aluresult = '0;
        ch_loaddata  = '0;
        ch_pcplus4   = '0;
        ch_immext    = '0;
        ch_rd        = '0;
        ch_regwrite  = '0;
    endtask

    task automatic set_ch(input int c, input logic [1:0] src, input logic [XLEN-1:0] val,
                          input logic [4:0] rd, input logic rw);
        ch_valid[c]     = 1'b1;
        ch_resultsrc[c] = src;
        ch_aluresult[c] = (src == 2'd0) ? val : 32'h0BAD_0000;
        ch_loaddata[c]  = (src == 2'd1) ? val : 32'h0BAD_0001;
        ch_pcplus4[c]   = (src == 2'd2) ? val : 32'h0BAD_0002;
        ch_immext[c]    = (src == 2'd3) ? val : 32'h0BAD_0003;
        ch_rd[c]        = rd;
        ch_regwrite[c]  = rw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   seen;
        logic [3:0] exp_tag;

        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Single load writeback, latency and rd_pending window
        set_ch(0, 2'd1, 32'hDEAD_BEEF, 5'd5, 1'b1);
        step();
        clear_inputs();
        chk("t1_pend5_c1", 64'(rd_pending[5]), 64'd1);
        step();
        chk("t1_we_c2", 64'(RegWriteW), 64'd1);
        chk("t1_rd_c2", 64'(RdW), 64'd5);
        chk("t1_res_c2", 64'(ResultW), 64'hDEAD_BEEF);
        chk("t1_pend5_c2", 64'(rd_pending[5]), 64'd1);
        step();
        chk("t1_pend5_c3", 64'(rd_pending[5]), 64'd0);

        // x0 write suppression
        set_ch(1, 2'd3, 32'h0000_0123, 5'd0, 1'b1);
        step();
        clear_inputs();
        chk("x0_pend", 64'(rd_pending), 64'd0);
        step();
        chk("x0_we", 64'(RegWriteW), 64'd0);
        chk("x0_res", 64'(ResultW), 64'h123);
        step();

        // Fairness: both channels always valid; tagged data reveals the grant order
        for (int n = 0; n < 8; n++) begin
            set_ch(0, 2'd0, 32'hA000_0000 | 32'(n), 5'(n + 1), 1'b1);
            set_ch(1, 2'd2, 32'hB000_0000 | 32'(n), 5'(n + 16), 1'b1);
            step();
        end
        clear_inputs();
        repeat (2 * DEPTH + 2) step();

        seen = 0;
        for (int n = 0; n < 8; n++) begin
            set_ch(0, 2'd0, 32'hA100_0000 | 32'(n), 5'd3, 1'b1);
            set_ch(1, 2'd0, 32'hB100_0000 | 32'(n), 5'd4, 1'b1);
            step();
            if (RegWriteW) begin
                exp_tag = (seen % 2 == 0) ? 4'hA : 4'hB;
                chk("fair_order", 64'(ResultW[31:28]), 64'(exp_tag));
                seen++;
            end
        end
        clear_inputs();
        repeat (2 * DEPTH + 2) step();

        // Backpressure: ch0 held valid while ch1 competes every cycle
        for (int n = 0; n < 10; n++) begin
            set_ch(0, 2'd1, 32'hC000_0000 | 32'(n), 5'd9, 1'b1);
            set_ch(1, 2'd1, 32'hD000_0000 | 32'(n), 5'd10, 1'b1);
            step();
        end
        clear_inputs();
        repeat (2 * DEPTH + 2) step();

        // Reset with entries queued: outputs clear immediately, nothing stale comes out afterwards
        set_ch(0, 2'd0, 32'h1111_1111, 5'd12, 1'b1);
        set_ch(1, 2'd0, 32'h2222_2222, 5'd13, 1'b1);
        step();
        set_ch(0, 2'd0, 32'h3333_3333, 5'd14, 1'b1);
        step();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("rst_nostale", 64'(RegWriteW), 64'd0);
        end

        // Idle hold after one write
        set_ch(0, 2'd0, 32'h0000_0055, 5'd7, 1'b1);
        step();
        clear_inputs();
        step();
        chk("hold_we1", 64'(RegWriteW), 64'd1);
        repeat (10) step();
        chk("hold_we", 64'(RegWriteW), 64'd0);
        chk("hold_rd", 64'(RdW), 64'd7);
        chk("hold_res", 64'(ResultW), 64'h55);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_valid[c]     = ($urandom_range(0, 3) != 0);
                ch_resultsrc[c] = 2'($urandom_range(0, 3));
                ch_aluresult[c] = $urandom;
                ch_loaddata[c]  = $urandom;
                ch_pcplus4[c]   = $urandom;
                ch_immext[c]    = $urandom;
                ch_rd[c]        = 5'($urandom_range(0, 31));
                ch_regwrite[c]  = ($urandom_range(0, 4) != 0);
            end
            step();
        end
        clear_inputs();
        repeat (2 * DEPTH + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
